// File: rtl/sign_addsub_pkg.sv
// Shared definitions for the sequential signed add/subtract unit:
// FSM state encodings, control/status bit positions, output-enable pattern.
package sign_addsub_pkg;

  // State encodings kept as plain constants for legacy tooling, wrapped in an enum
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD_A = 3'd1;
  localparam logic [2:0] ST_LOAD_B = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_OUT    = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_LOAD_A = ST_LOAD_A,
    S_LOAD_B = ST_LOAD_B,
    S_EXEC   = ST_EXEC,
    S_OUT    = ST_OUT
  } state_e;

  // uio_in control bit positions
  localparam int CTL_WR  = 0;
  localparam int CTL_OP  = 1;
  localparam int CTL_ACC = 2;
  localparam int CTL_CLR = 3;
  localparam int CTL_RD  = 4;

  // uio_out status bit positions
  localparam int STS_OVF   = 5;
  localparam int STS_VALID = 6;
  localparam int STS_BUSY  = 7;

  // Upper three uio pins are outputs, lower five are inputs
  localparam logic [7:0] UIO_OE_VAL = 8'b1110_0000;

endpackage

// File: rtl/sign_addsub_core.sv
// Combinational WIDTH-bit signed add/subtract with overflow detection.
// Optional saturation on overflow when SIGN_ADDSUB_SAT_EN is defined,
// otherwise the result wraps modulo 2^WIDTH.
module sign_addsub_core #(
  parameter int WIDTH = 16
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic                    op,
  output logic signed [WIDTH-1:0] r,
  output logic                    ovf
);

`ifdef SIGN_ADDSUB_SAT_EN
  // Clamp a WIDTH+1 bit true result to the representable WIDTH-bit range
  function automatic logic signed [WIDTH-1:0] saturate(input logic signed [WIDTH:0] v);
    if (v[WIDTH] ^ v[WIDTH-1])
      return v[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      return v[WIDTH-1:0];
  endfunction
`endif

  logic signed [WIDTH:0] a_ext;
  logic signed [WIDTH:0] b_ext;
  logic signed [WIDTH:0] full;

  // One extra bit holds the exact result; overflow when the top two bits disagree
  always_comb begin
    a_ext = $signed({a[WIDTH-1], a});
    b_ext = $signed({b[WIDTH-1], b});
    full  = op ? (a_ext - b_ext) : (a_ext + b_ext);
    ovf   = full[WIDTH] ^ full[WIDTH-1];
`ifdef SIGN_ADDSUB_SAT_EN
    r     = saturate(full);
`else
    r     = full[WIDTH-1:0];
`endif
  end

endmodule

// File: rtl/tt_um_sign_addsub_seq.sv
// Byte-serial signed add/subtract unit with accumulator.
// Operands arrive little-endian one byte per wr strobe; the result is read
// back one byte per rd strobe. Optional macro SIGN_ADDSUB_SAT_EN selects
// saturating instead of wrapping arithmetic (implemented in sign_addsub_core).
import sign_addsub_pkg::*;

module tt_um_sign_addsub_seq #(
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int         NBYTES = WIDTH / 8;
  localparam logic [3:0] LAST   = 4'(NBYTES - 1);

  state_e                  state;
  logic [3:0]              cnt;
  logic signed [WIDTH-1:0] a_reg;
  logic signed [WIDTH-1:0] b_reg;
  logic signed [WIDTH-1:0] r_reg;
  logic signed [WIDTH-1:0] acc_reg;
  logic                    op_reg;
  logic                    ovf_reg;
  logic signed [WIDTH-1:0] core_r;
  logic                    core_ovf;

  logic wr, op, acc, clr, rd;
  logic unused_ctl;

  assign wr         = uio_in[CTL_WR];
  assign op         = uio_in[CTL_OP];
  assign acc        = uio_in[CTL_ACC];
  assign clr        = uio_in[CTL_CLR];
  assign rd         = uio_in[CTL_RD];
  assign unused_ctl = &{1'b0, uio_in[7:5]};

  sign_addsub_core #(.WIDTH(WIDTH)) u_core (
    .a   (a_reg),
    .b   (b_reg),
    .op  (op_reg),
    .r   (core_r),
    .ovf (core_ovf)
  );

  // Transaction FSM: operand capture, single-cycle execute, byte readout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      r_reg   <= '0;
      acc_reg <= '0;
      op_reg  <= 1'b0;
      ovf_reg <= 1'b0;
    end else if (ena) begin
      case (state)
        S_IDLE: begin
          if (clr) begin
            acc_reg <= '0;
          end else if (wr) begin
            op_reg  <= op;
            ovf_reg <= 1'b0;
            if (acc) begin
              a_reg      <= acc_reg;
              b_reg[7:0] <= ui_in;
              if (NBYTES == 1) begin
                state <= S_EXEC;
                cnt   <= '0;
              end else begin
                state <= S_LOAD_B;
                cnt   <= 4'd1;
              end
            end else begin
              a_reg[7:0] <= ui_in;
              if (NBYTES == 1) begin
                state <= S_LOAD_B;
                cnt   <= '0;
              end else begin
                state <= S_LOAD_A;
                cnt   <= 4'd1;
              end
            end
          end
        end
        S_LOAD_A: begin
          if (wr) begin
            a_reg[{cnt, 3'b000} +: 8] <= ui_in;
            if (cnt == LAST) begin
              state <= S_LOAD_B;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        S_LOAD_B: begin
          if (wr) begin
            b_reg[{cnt, 3'b000} +: 8] <= ui_in;
            if (cnt == LAST) begin
              state <= S_EXEC;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        S_EXEC: begin
          r_reg   <= core_r;
          acc_reg <= core_r;
          ovf_reg <= core_ovf;
          state   <= S_OUT;
          cnt     <= '0;
        end
        S_OUT: begin
          if (rd) begin
            if (cnt == LAST) begin
              state <= S_IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Result byte is only presented while the result is valid
  always_comb begin
    uo_out = '0;
    if (state == S_OUT)
      uo_out = r_reg[{cnt, 3'b000} +: 8];
  end

  // Status pins: overflow, result valid, busy
  always_comb begin
    uio_out            = '0;
    uio_out[STS_OVF]   = ovf_reg;
    uio_out[STS_VALID] = (state == S_OUT);
    uio_out[STS_BUSY]  = (state != S_IDLE);
  end

  assign uio_oe = UIO_OE_VAL;

endmodule

// File: tb/tb_tt_um_sign_addsub_seq.sv
// Scoreboard bench for tt_um_sign_addsub_seq (WIDTH=16): the driver pushes
// hand-computed result bytes into a queue, a monitor pops them whenever a
// result byte is read out.
module tb_tt_um_sign_addsub_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    logic       ovf;
  } exp_t;
  exp_t q[$];

  tt_um_sign_addsub_seq #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] ctl(input logic wr, input logic op, input logic acc,
                                     input logic clr, input logic rd);
    return {3'b000, rd, clr, acc, op, wr};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] d, input logic [7:0] c);
    ui_in  = d;
    uio_in = c;
    tick();
    ui_in  = 8'h00;
    uio_in = 8'h00;
  endtask

  task automatic push_res(input logic [15:0] r, input logic ovf);
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      e.data = r[8*i +: 8];
      e.ovf  = ovf;
      q.push_back(e);
    end
  endtask

  task automatic read_out();
    int n = 0;
    while (!uio_out[6] && n < 10) begin
      tick();
      n++;
    end
    if (!uio_out[6]) begin
      checks++;
      errors++;
      $display("FAIL res_valid_timeout: got 0 required 1");
      q.delete();
      return;
    end
    for (int i = 0; i < 2; i++) drive(8'h00, ctl(0, 0, 0, 0, 1));
  endtask

  task automatic do_txn(input logic [15:0] a, input logic [15:0] b, input logic op,
                        input logic [15:0] r, input logic ovf);
    push_res(r, ovf);
    drive(a[7:0],  ctl(1, op, 0, 0, 0));
    drive(a[15:8], ctl(1, 0, 0, 0, 0));
    drive(b[7:0],  ctl(1, 0, 0, 0, 0));
    drive(b[15:8], ctl(1, 0, 0, 0, 0));
    read_out();
  endtask

  task automatic do_acc(input logic [15:0] b, input logic op,
                        input logic [15:0] r, input logic ovf);
    push_res(r, ovf);
    drive(b[7:0],  ctl(1, op, 1, 0, 0));
    drive(b[15:8], ctl(1, 0, 0, 0, 0));
    read_out();
  endtask

  // Monitor: a rd strobe while the result is valid consumes one result byte
  always @(negedge clk) begin
    if (rst_n && ena && uio_in[4] && uio_out[6]) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read: got 0x%0h required no read", uo_out);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("result_byte", {24'h0, uo_out}, {24'h0, e.data});
        check("ovf", {31'h0, uio_out[5]}, {31'h0, e.ovf});
      end
    end
  end

  initial begin
    logic [15:0] sub_exp;
    logic [15:0] pos_exp;
`ifdef SIGN_ADDSUB_SAT_EN
    sub_exp = 16'h8000;
    pos_exp = 16'h7FFF;
`else
    sub_exp = 16'h7FFF;
    pos_exp = 16'h8000;
`endif

    // Reset state
    #3;
    check("reset_uo_out", {24'h0, uo_out}, 32'h0);
    check("reset_uio_out", {24'h0, uio_out}, 32'h0);
    check("reset_uio_oe", {24'h0, uio_oe}, 32'hE0);
    tick();
    rst_n = 1'b1;
    tick();

    // Plain add: 0x1234 + 0x0101 = 0x1335
    do_txn(16'h1234, 16'h0101, 1'b0, 16'h1335, 1'b0);
    check("busy_after_read", {31'h0, uio_out[7]}, 32'h0);
    check("uo_out_idle", {24'h0, uo_out}, 32'h0);

    // Subtract with overflow: 0x8000 - 0x0001
    do_txn(16'h8000, 16'h0001, 1'b1, sub_exp, 1'b1);
    check("ovf_sticky_idle", {31'h0, uio_out[5]}, 32'h1);

    // Positive overflow: 0x7FFF + 0x0001
    do_txn(16'h7FFF, 16'h0001, 1'b0, pos_exp, 1'b1);

    // Accumulate: clear then add 0x0010 three times
    drive(8'h00, ctl(0, 0, 0, 1, 0));
    check("ovf_kept_by_clr", {31'h0, uio_out[5]}, 32'h1);
    do_acc(16'h0010, 1'b0, 16'h0010, 1'b0);
    do_acc(16'h0010, 1'b0, 16'h0020, 1'b0);
    do_acc(16'h0010, 1'b0, 16'h0030, 1'b0);

    // Accumulator subtract: 0x0030 - 0x0040 = 0xFFF0
    do_acc(16'h0040, 1'b1, 16'hFFF0, 1'b0);

    // Simultaneous clr+wr with accumulator 0x0005: byte dropped, acc cleared
    drive(8'h00, ctl(0, 0, 0, 1, 0));
    do_acc(16'h0005, 1'b0, 16'h0005, 1'b0);
    drive(8'h77, ctl(1, 0, 0, 1, 0));
    check("clr_wr_busy", {31'h0, uio_out[7]}, 32'h0);
    do_acc(16'h0000, 1'b0, 16'h0000, 1'b0);

    // Reset mid-load discards the transaction
    drive(8'hAA, ctl(1, 0, 0, 0, 0));
    check("busy_mid_load", {31'h0, uio_out[7]}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("midrst_uo_out", {24'h0, uo_out}, 32'h0);
    check("midrst_uio_out", {24'h0, uio_out}, 32'h0);
    check("midrst_uio_oe", {24'h0, uio_oe}, 32'hE0);
    tick();
    rst_n = 1'b1;
    tick();
    do_txn(16'h0002, 16'h0003, 1'b0, 16'h0005, 1'b0);

    // ena low during LOAD_B: strobes ignored, state held
    push_res(16'h0302, 1'b0);
    drive(8'h00, ctl(1, 0, 0, 0, 0));
    drive(8'h01, ctl(1, 0, 0, 0, 0));
    drive(8'h02, ctl(1, 0, 0, 0, 0));
    ena = 1'b0;
    for (int i = 0; i < 5; i++) drive(8'hFF, ctl(1, 0, 0, 0, 0));
    check("ena_low_busy", {31'h0, uio_out[7]}, 32'h1);
    check("ena_low_valid", {31'h0, uio_out[6]}, 32'h0);
    ena = 1'b1;
    drive(8'h02, ctl(1, 0, 0, 0, 0));
    read_out();

    check("queue_drained", q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
